mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signal bundle for mem_arbiter.
// slave = arbiter view, master = requester/memory view.
interface mem_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
);
  logic              i_read;
  logic [31:0]       i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [31:0]       d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [31:0]       pmem_addr;
  logic [BEAT_W-1:0] pmem_wdata;
  logic [BEAT_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_read, i_addr,
    output i_rdata, i_resp,
    input  d_read, d_write, d_addr, d_wdata,
    output d_rdata, d_resp,
    output pmem_read, pmem_write,
    output pmem_addr, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output i_read, i_addr,
    input  i_rdata, i_resp,
    output d_read, d_write, d_addr, d_wdata,
    input  d_rdata, d_resp,
    input  pmem_read, pmem_write,
    input  pmem_addr, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/mem_arbiter.sv
// I/D cache line arbiter onto a beat-wide physical memory port.
// ARB_RR_EN selects round-robin instead of fixed D-over-I priority.
module mem_arbiter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF   = $clog2(LINE_W / 8);

  localparam logic [31:0]   AMASK = ~((32'd1 << OFF) - 32'd1);
  localparam logic [CW-1:0] LAST  = CW'(BEATS - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_IRD  = 3'd1;
  localparam logic [2:0] S_DRD  = 3'd2;
  localparam logic [2:0] S_DWR  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]                   r_state;
  logic [CW-1:0]                r_cnt;
  logic [31:0]                  r_addr;
  logic [BEATS-1:0][BEAT_W-1:0] r_line;
  logic                         r_own_d;

  logic        w_d_req;
  logic        w_gnt_d;
  logic        w_gnt_i;
  logic [31:0] w_gnt_addr;
  logic        w_rd;
  logic        w_xfer;

`ifdef ARB_RR_EN
  logic r_last_d;
`endif

  always_comb begin
    w_d_req = bus.d_read | bus.d_write;
`ifdef ARB_RR_EN
    w_gnt_d = w_d_req & (~bus.i_read | ~r_last_d);
`else
    w_gnt_d = w_d_req;
`endif
    w_gnt_i = bus.i_read & ~w_gnt_d;
    w_gnt_addr = w_gnt_d ? (bus.d_addr & AMASK)
                         : (bus.i_addr & AMASK);
  end

  assign w_rd   = (r_state == S_IRD) | (r_state == S_DRD);
  assign w_xfer = w_rd | (r_state == S_DWR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_line  <= '0;
      r_own_d <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_gnt_d | w_gnt_i) begin
            r_addr  <= w_gnt_addr;
            r_cnt   <= '0;
            r_own_d <= w_gnt_d;
            if (w_gnt_d & bus.d_write)
              r_line <= bus.d_wdata;
            if (w_gnt_i)
              r_state <= S_IRD;
            else if (bus.d_write)
              r_state <= S_DWR;
            else
              r_state <= S_DRD;
          end
        end
        S_IRD, S_DRD, S_DWR: begin
          if (bus.pmem_resp) begin
            // write line stays intact so beats go out unmodified
            if (w_rd)
              r_line[r_cnt] <= bus.pmem_rdata;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST)
              r_state <= S_DONE;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_last_d <= 1'b1;
    else if ((r_state == S_IDLE) && (w_gnt_d | w_gnt_i))
      r_last_d <= w_gnt_d;
  end
`endif

  assign bus.pmem_read  = w_rd;
  assign bus.pmem_write = (r_state == S_DWR);
  assign bus.pmem_addr  = r_addr;
  assign bus.pmem_wdata = r_line[r_cnt];

  assign bus.i_resp  = (r_state == S_DONE) & ~r_own_d;
  assign bus.d_resp  = (r_state == S_DONE) & r_own_d;
  assign bus.i_rdata = r_line;
  assign bus.d_rdata = r_line;

  logic w_unused;
  assign w_unused = w_xfer;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter with a
// behavioural beat-wise memory responder.
module tb_mem_arbiter;
  localparam int LW = 256;
  localparam int BW = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.LINE_W(LW), .BEAT_W(BW)) bus();

  mem_arbiter #(.LINE_W(LW), .BEAT_W(BW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string       nm;
    logic        ir, dr, dw;
    logic [31:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] mline;
    int          wt;
    logic [31:0] eaddr;
    logic        ewr;
    int          ei, ed, ecyc, elat;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int mem_wait = 0;
  logic [LW-1:0] mem_line = '0;
  logic [LW-1:0] wcap = '0;
  int mb = 0;
  int wcnt = 0;
  int n_iresp = 0, n_dresp = 0, n_both = 0;
  logic [7:0] ord[$];
  vec_t tv[6];

  initial begin
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.pmem_resp = 1'b0;
      if (!rst) begin
        mb = 0; wcnt = 0;
      end else if (bus.pmem_read || bus.pmem_write) begin
        if (wcnt == mem_wait) begin
          bus.pmem_resp  = 1'b1;
          bus.pmem_rdata = mem_line[mb*BW +: BW];
          wcap[mb*BW +: BW] = bus.pmem_wdata;
          mb = (mb + 1) % 4;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        mb = 0; wcnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.i_resp) begin n_iresp++; ord.push_back("I"); end
    if (bus.d_resp) begin n_dresp++; ord.push_back("D"); end
    if (bus.pmem_read && bus.pmem_write) n_both++;
  end

  task automatic chk(input string nm,
                     input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    string nm, logic ir, logic dr, logic dw,
    logic [31:0] addr, logic [LW-1:0] wd,
    logic [LW-1:0] ml, int wt, logic [31:0] ea,
    logic ewr, int ei, int ed, int ecyc, int elat);
    vec_t v;
    v.nm = nm; v.ir = ir; v.dr = dr; v.dw = dw;
    v.addr = addr; v.wdata = wd; v.mline = ml;
    v.wt = wt; v.eaddr = ea; v.ewr = ewr;
    v.ei = ei; v.ed = ed; v.ecyc = ecyc; v.elat = elat;
    return v;
  endfunction

  task automatic drop_reqs();
    bus.i_read = 1'b0;
    bus.d_read = 1'b0;
    bus.d_write = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drop_reqs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_txn(input vec_t v);
    int cyc, act, i0, d0;
    logic rd_s, wr_s, got;
    logic [31:0] a_s;
    logic [LW-1:0] rdat;
    mem_line = v.mline;
    mem_wait = v.wt;
    wcap = '0;
    i0 = n_iresp; d0 = n_dresp;
    cyc = 0; act = 0; rd_s = 0; wr_s = 0;
    got = 0; a_s = '0; rdat = '0;
    @(posedge clk); #1;
    bus.i_read  = v.ir;
    bus.d_read  = v.dr;
    bus.d_write = v.dw;
    bus.i_addr  = v.addr;
    bus.d_addr  = v.addr;
    bus.d_wdata = v.wdata;
    while (!got && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.pmem_read) rd_s = 1'b1;
      if (bus.pmem_write) wr_s = 1'b1;
      if (bus.pmem_read || bus.pmem_write) begin
        act++;
        a_s = bus.pmem_addr;
      end
      if (bus.i_resp || bus.d_resp) begin
        got = 1'b1;
        rdat = bus.i_resp ? bus.i_rdata : bus.d_rdata;
      end
    end
    drop_reqs();
    repeat (3) @(posedge clk);
    chk({v.nm, "_timeout"}, LW'(got), 1);
    chk({v.nm, "_lat"}, cyc, v.elat);
    chk({v.nm, "_addr"}, a_s, v.eaddr);
    chk({v.nm, "_rd_seen"}, rd_s, !v.ewr);
    chk({v.nm, "_wr_seen"}, wr_s, v.ewr);
    chk({v.nm, "_act_cyc"}, act, v.ecyc);
    if (v.ewr)
      chk({v.nm, "_wbeats"}, wcap, v.wdata);
    else
      chk({v.nm, "_rdata"}, rdat, v.mline);
    chk({v.nm, "_iresp"}, n_iresp - i0, v.ei);
    chk({v.nm, "_dresp"}, n_dresp - d0, v.ed);
  endtask

  initial begin
    logic [7:0] e2[2];
    logic [7:0] e4[4];
    int cnt, cyc, d0;
    vec_t vr;

    tv[0] = mk("i_fill", 1, 0, 0, 32'h0000_0064, '0,
      {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
      0, 32'h0000_0060, 0, 1, 0, 4, 5);
    tv[1] = mk("d_wb", 0, 0, 1, 32'h0000_0100,
      {64'hDDDD_0003_DDDD_0003, 64'hCCCC_0002_CCCC_0002,
       64'hBBBB_0001_BBBB_0001, 64'hAAAA_0000_AAAA_0000},
      {4{64'h5A5A_5A5A_5A5A_5A5A}},
      3, 32'h0000_0100, 1, 0, 1, 16, 17);
    tv[2] = mk("d_fill", 0, 1, 0, 32'h1234_5678, '0,
      {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
       64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002},
      1, 32'h1234_5660, 0, 0, 1, 8, 9);
    tv[3] = mk("d_rw_both", 0, 1, 1, 32'h0000_002C,
      {64'h4, 64'h3, 64'h2, 64'h1},
      {4{64'hFFFF_0000_FFFF_0000}},
      0, 32'h0000_0020, 1, 0, 1, 4, 5);
    tv[4] = mk("i_top", 1, 0, 0, 32'hFFFF_FFFF, '0,
      {64'h8, 64'h7, 64'h6, 64'h5},
      2, 32'hFFFF_FFE0, 0, 1, 0, 12, 13);
    tv[5] = mk("d_wb0", 0, 0, 1, 32'h0000_0000,
      {64'h1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001},
      '0, 0, 32'h0000_0000, 1, 0, 1, 4, 5);

    rst = 1'b0;
    drop_reqs();
    bus.i_addr = '0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    #3;
    chk("rst_pmem_rw", {bus.pmem_read, bus.pmem_write}, 0);
    chk("rst_pmem_addr", bus.pmem_addr, 0);
    chk("rst_pmem_wdata", bus.pmem_wdata, 0);
    chk("rst_resp", {bus.i_resp, bus.d_resp}, 0);
    chk("rst_rdata", bus.i_rdata | bus.d_rdata, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_idle",
        {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp}, 0);

    for (int k = 0; k < 6; k++)
      run_txn(tv[k]);

`ifdef ARB_RR_EN
    e2[0] = "I"; e2[1] = "D";
    e4[0] = "I"; e4[1] = "D"; e4[2] = "I"; e4[3] = "D";
`else
    e2[0] = "D"; e2[1] = "I";
    e4[0] = "D"; e4[1] = "D"; e4[2] = "D"; e4[3] = "D";
`endif

    do_reset();
    mem_wait = 0;
    ord.delete();
    @(posedge clk); #1;
    bus.i_addr = 32'h0000_0200;
    bus.d_addr = 32'h0000_0300;
    bus.i_read = 1'b1;
    bus.d_read = 1'b1;
    cyc = 0;
    while ((bus.i_read || bus.d_read) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.d_resp) bus.d_read = 1'b0;
      if (bus.i_resp) bus.i_read = 1'b0;
    end
    drop_reqs();
    repeat (2) @(posedge clk);
    chk("sim_count", ord.size(), 2);
    if (ord.size() == 2) begin
      chk("sim_first", ord[0], e2[0]);
      chk("sim_second", ord[1], e2[1]);
    end

    do_reset();
    ord.delete();
    @(posedge clk); #1;
    bus.i_read = 1'b1;
    bus.d_read = 1'b1;
    cnt = 0; cyc = 0;
    while (cnt < 4 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.i_resp || bus.d_resp) cnt++;
    end
    drop_reqs();
    repeat (2) @(posedge clk);
    chk("hold_count", ord.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < ord.size())
        chk($sformatf("hold_gnt%0d", k), ord[k], e4[k]);

    do_reset();
    vr = tv[2];
    mem_line = vr.mline;
    mem_wait = 1;
    d0 = n_dresp;
    @(posedge clk); #1;
    bus.d_addr = 32'h0000_0440;
    bus.d_read = 1'b1;
    cyc = 0;
    while (mb != 2 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("mid_reach_beat2", mb, 2);
    @(posedge clk); #2;
    rst = 1'b0;
    bus.d_read = 1'b0;
    #1;
    chk("mid_rst_rw", {bus.pmem_read, bus.pmem_write}, 0);
    chk("mid_rst_addr", bus.pmem_addr, 0);
    chk("mid_rst_resp", {bus.i_resp, bus.d_resp}, 0);
    chk("mid_rst_rdata", bus.d_rdata, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    chk("mid_no_dresp", n_dresp - d0, 0);
    run_txn(tv[0]);

    chk("never_both_rw", n_both, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
